// File: rtl/speck_key_schedule_inv_pkg.sv
// Shared SPECK128/128 constants, FSM state encoding and rotate helpers.
// The package is named speck_pkg because the forward key schedule and the
// round cores import the same definitions.
package speck_pkg;

   localparam int WORD           = 64;
   localparam int ROT_ALPHA      = 8;
   localparam int ROT_BETA       = 3;
   localparam int DEFAULT_ROUNDS = 32;
   localparam int IDX_W          = 5;

   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_LOAD = 4'd1,
      ST_EMIT = 4'd2,
      ST_STEP = 4'd3,
      ST_DONE = 4'd4
   } state_t;

   function automatic logic [WORD-1:0] rol(input logic [WORD-1:0] x, input int amt);
      return (x << amt) | (x >> (WORD - amt));
   endfunction

   function automatic logic [WORD-1:0] ror(input logic [WORD-1:0] x, input int amt);
      return (x >> amt) | (x << (WORD - amt));
   endfunction

endpackage

// File: rtl/speck_key_schedule_inv_if.sv
// Round-key stream from the inverse key schedule to the decryption datapath.
// The master drives key/index/valid; the slave answers with ready.
interface speck_key_schedule_inv_if;
   import speck_pkg::*;

   logic [WORD-1:0]  round_key;
   logic [IDX_W-1:0] round_idx;
   logic             round_key_valid;
   logic             round_key_ready;

   modport master (
      output round_key,
      output round_idx,
      output round_key_valid,
      input  round_key_ready
   );

   modport slave (
      input  round_key,
      input  round_idx,
      input  round_key_valid,
      output round_key_ready
   );

endinterface

// File: rtl/speck_key_schedule_inv_round_key.sv
// One inverse SPECK key-schedule round: recovers {l[i-1], k[i-1]} from
// {l[i], k[i]}. Purely combinational so the full decryption core can reuse it.
module speck_inv_round_key
   import speck_pkg::*;
(
   input  logic [WORD-1:0]  k,
   input  logic [WORD-1:0]  l,
   input  logic [IDX_W-1:0] i,
   output logic [WORD-1:0]  k_new,
   output logic [WORD-1:0]  l_new
);

   logic [IDX_W-1:0] idx_dec;
   logic [WORD-1:0]  prev_idx;

   // Undo the forward round: k first, then l using the recovered k and the
   // forward round counter (i-1) zero-extended to a full word.
   always_comb begin
      idx_dec  = i - IDX_W'(1);
      prev_idx = {{(WORD - IDX_W){1'b0}}, idx_dec};
      k_new    = ror(k ^ l, ROT_BETA);
      l_new    = rol((l ^ prev_idx) - k_new, ROT_ALPHA);
   end

endmodule

// File: rtl/speck_key_schedule_inv.sv
// Inverse SPECK128/128 key schedule: walks the final schedule state backwards,
// streaming k[R-1] .. k[0] on a valid/ready handshake, then reports the
// recovered master key {l[0], k[0]} alongside a one-cycle finished pulse.
module speck_key_schedule_inv
   import speck_pkg::*;
#(
   parameter int ROUNDS = DEFAULT_ROUNDS
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   signal_start,
   input  logic [2*WORD-1:0]      key_in,
   output logic                   busy,
   output logic                   finished,
   output logic [2*WORD-1:0]      out_key,
   output logic [3:0]             state_response,
   speck_key_schedule_inv_if.master rk
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

   state_t            state_q, state_d;
   logic [WORD-1:0]   k_q, k_d;
   logic [WORD-1:0]   l_q, l_d;
   logic [IDX_W-1:0]  i_q, i_d;
   logic [WORD-1:0]   round_key_q, round_key_d;
   logic [IDX_W-1:0]  round_idx_q, round_idx_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              finished_q, finished_d;
   logic [2*WORD-1:0] out_key_q, out_key_d;

   logic [WORD-1:0]   k_new;
   logic [WORD-1:0]   l_new;

   speck_inv_round_key u_inv_round (
      .k     (k_q),
      .l     (l_q),
      .i     (i_q),
      .k_new (k_new),
      .l_new (l_new)
   );

   // Next-state and output computation; everything holds unless a state acts,
   // and finished falls back to zero so it can only ever be a single pulse.
   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      l_d         = l_q;
      i_d         = i_q;
      round_key_d = round_key_q;
      round_idx_d = round_idx_q;
      valid_d     = valid_q;
      busy_d      = busy_q;
      finished_d  = 1'b0;
      out_key_d   = out_key_q;

      case (state_q)
         ST_IDLE: begin
            if (signal_start) begin
               k_d     = key_in[WORD-1:0];
               l_d     = key_in[2*WORD-1:WORD];
               i_d     = LAST_IDX;
               busy_d  = 1'b1;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            round_key_d = k_q;
            round_idx_d = i_q;
            valid_d     = 1'b1;
            state_d     = ST_EMIT;
         end
         ST_EMIT: begin
            if (valid_q && rk.round_key_ready) begin
               valid_d = 1'b0;
               state_d = (i_q == '0) ? ST_DONE : ST_STEP;
            end
         end
         ST_STEP: begin
            k_d         = k_new;
            l_d         = l_new;
            i_d         = i_q - IDX_W'(1);
            round_key_d = k_new;
            round_idx_d = i_q - IDX_W'(1);
            valid_d     = 1'b1;
            state_d     = ST_EMIT;
         end
         ST_DONE: begin
            out_key_d  = {l_q, k_q};
            finished_d = 1'b1;
            busy_d     = 1'b0;
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register with synchronous reset that aborts any run in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         k_q         <= '0;
         l_q         <= '0;
         i_q         <= '0;
         round_key_q <= '0;
         round_idx_q <= '0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         finished_q  <= 1'b0;
         out_key_q   <= '0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         l_q         <= l_d;
         i_q         <= i_d;
         round_key_q <= round_key_d;
         round_idx_q <= round_idx_d;
         valid_q     <= valid_d;
         busy_q      <= busy_d;
         finished_q  <= finished_d;
         out_key_q   <= out_key_d;
      end
   end

   assign rk.round_key       = round_key_q;
   assign rk.round_idx       = round_idx_q;
   assign rk.round_key_valid = valid_q;
   assign busy               = busy_q;
   assign finished           = finished_q;
   assign out_key            = out_key_q;
   assign state_response     = state_q;

endmodule
